// File: rtl/rv_mem_arbiter_if.sv
// Request/response bus between the rv32 core ports, the arbiter and the
// unified word-wide memory. The slave modport is the arbiter's view.
interface rv_mem_arbiter_if #(
    parameter int ADDR_W = 6
);
    // instruction fetch port
    logic              if_req_valid;
    logic              if_req_ready;
    logic [31:0]       if_addr;
    logic              if_rsp_valid;
    logic [31:0]       if_rdata;
    // load/store port
    logic              d_req_valid;
    logic              d_req_ready;
    logic              d_we;
    logic [1:0]        d_size;
    logic              d_unsigned;
    logic [31:0]       d_addr;
    logic [31:0]       d_wdata;
    logic              d_rsp_valid;
    logic [31:0]       d_rdata;
    logic              d_err;
    // memory port
    logic              mem_en;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport master (
        output if_req_valid, if_addr,
        output d_req_valid, d_we, d_size, d_unsigned, d_addr, d_wdata,
        output mem_rdata,
        input  if_req_ready, if_rsp_valid, if_rdata,
        input  d_req_ready, d_rsp_valid, d_rdata, d_err,
        input  mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );

    modport slave (
        input  if_req_valid, if_addr,
        input  d_req_valid, d_we, d_size, d_unsigned, d_addr, d_wdata,
        input  mem_rdata,
        output if_req_ready, if_rsp_valid, if_rdata,
        output d_req_ready, d_rsp_valid, d_rdata, d_err,
        output mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );
endinterface

// File: rtl/rv_mem_arbiter.sv
// Single-port arbiter/sequencer sharing one word-wide memory between the
// rv32 fetch port and load/store port. One transaction in flight at a time:
// handshake, memory access, response. Data normally wins arbitration; a fetch
// is forced through after MAX_DATA_STREAK consecutive data grants.
//
// Optional feature: define ARB_MISALIGN_TRAP_EN to flag misaligned data
// accesses with d_err instead of silently aligning them (memory untouched).
//
// state  | meaning
// IDLE   | waiting for a request, readies driven combinationally
// ACCESS | memory driven from the latched request
// RESP   | response pulse to the owning port, read data from mem_rdata
module rv_mem_arbiter #(
    parameter int ADDR_W          = 6,
    parameter int MAX_DATA_STREAK = 4
) (
    input logic             clk,
    input logic             rst_n,
    rv_mem_arbiter_if.slave bus
);

    localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);
    localparam int BA_W     = ADDR_W + 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [STREAK_W-1:0] streak_q, streak_d;

    logic                owner_d_q;
    logic [BA_W-1:0]     addr_q;
    logic [1:0]          size_q;
    logic                we_q;
    logic                uns_q;
    logic [31:0]         wdata_q;

    logic                streak_full;
    logic                grant_d;
    logic                grant_f;
    logic                accept;
    logic [7:0]          rd_byte;
    logic [15:0]         rd_half;
    logic [31:0]         load_data;

`ifdef ARB_MISALIGN_TRAP_EN
    logic                err_q;
    logic                misaligned;
`endif

    // Byte address bits above the memory size wrap; fetch low bits are ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.if_addr[31:BA_W], bus.if_addr[1:0], bus.d_addr[31:BA_W]};

    // Arbitration: data wins unless the fetch has been starved long enough.
    always_comb begin
        streak_full = (streak_q == STREAK_W'(MAX_DATA_STREAK));
        grant_d     = bus.d_req_valid && !(bus.if_req_valid && streak_full);
        grant_f     = bus.if_req_valid && !grant_d;
        accept      = rst_n && (state_q == ST_IDLE) && (grant_d || grant_f);
    end

`ifdef ARB_MISALIGN_TRAP_EN
    // Misalignment of the incoming data request.
    always_comb begin
        case (bus.d_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = bus.d_addr[0];
            2'b10:   misaligned = |bus.d_addr[1:0];
            default: misaligned = 1'b1;
        endcase
    end
`endif

    // State and starvation counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
        end
    end

    // Latch the granted request so the requester may change its inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_d_q <= 1'b0;
            addr_q    <= '0;
            size_q    <= 2'b00;
            we_q      <= 1'b0;
            uns_q     <= 1'b0;
            wdata_q   <= '0;
`ifdef ARB_MISALIGN_TRAP_EN
            err_q     <= 1'b0;
`endif
        end else if (accept) begin
            owner_d_q <= grant_d;
            if (grant_d) begin
                addr_q  <= bus.d_addr[BA_W-1:0];
                size_q  <= bus.d_size;
                we_q    <= bus.d_we;
                uns_q   <= bus.d_unsigned;
                wdata_q <= bus.d_wdata;
            end else begin
                addr_q  <= {bus.if_addr[BA_W-1:2], 2'b00};
                size_q  <= 2'b10;
                we_q    <= 1'b0;
                uns_q   <= 1'b0;
                wdata_q <= '0;
            end
`ifdef ARB_MISALIGN_TRAP_EN
            err_q     <= grant_d && misaligned;
`endif
        end
    end

    // Sub-word extraction and extension of load data.
    always_comb begin
        case (addr_q[1:0])
            2'd0:    rd_byte = bus.mem_rdata[7:0];
            2'd1:    rd_byte = bus.mem_rdata[15:8];
            2'd2:    rd_byte = bus.mem_rdata[23:16];
            default: rd_byte = bus.mem_rdata[31:24];
        endcase
        rd_half = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (size_q)
            2'b00:   load_data = {{24{~uns_q & rd_byte[7]}}, rd_byte};
            2'b01:   load_data = {{16{~uns_q & rd_half[15]}}, rd_half};
            default: load_data = bus.mem_rdata;
        endcase
    end

    // Next state, handshake, memory drive and response outputs.
    always_comb begin
        state_d          = state_q;
        streak_d         = streak_q;
        bus.if_req_ready = 1'b0;
        bus.d_req_ready  = 1'b0;
        bus.if_rsp_valid = 1'b0;
        bus.if_rdata     = '0;
        bus.d_rsp_valid  = 1'b0;
        bus.d_rdata      = '0;
        bus.d_err        = 1'b0;
        bus.mem_en       = 1'b0;
        bus.mem_we       = 1'b0;
        bus.mem_be       = 4'b0000;
        bus.mem_addr     = '0;
        bus.mem_wdata    = '0;
        case (state_q)
            ST_IDLE: begin
                bus.if_req_ready = rst_n && grant_f;
                bus.d_req_ready  = rst_n && grant_d;
                if (accept) begin
                    state_d = ST_ACCESS;
                    if (grant_f) begin
                        streak_d = '0;
                    end else if (bus.if_req_valid && !streak_full) begin
                        streak_d = streak_q + STREAK_W'(1);
                    end
                end
            end
            ST_ACCESS: begin
                state_d      = ST_RESP;
                bus.mem_en   = 1'b1;
                bus.mem_addr = addr_q[BA_W-1:2];
                if (we_q) begin
                    bus.mem_we = 1'b1;
                    case (size_q)
                        2'b00: begin
                            bus.mem_be    = 4'b0001 << addr_q[1:0];
                            bus.mem_wdata = {4{wdata_q[7:0]}};
                        end
                        2'b01: begin
                            bus.mem_be    = 4'b0011 << {addr_q[1], 1'b0};
                            bus.mem_wdata = {2{wdata_q[15:0]}};
                        end
                        default: begin
                            bus.mem_be    = 4'b1111;
                            bus.mem_wdata = wdata_q;
                        end
                    endcase
                end
`ifdef ARB_MISALIGN_TRAP_EN
                if (err_q) begin
                    bus.mem_en    = 1'b0;
                    bus.mem_we    = 1'b0;
                    bus.mem_be    = 4'b0000;
                    bus.mem_wdata = '0;
                end
`endif
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                if (owner_d_q) begin
                    bus.d_rsp_valid = 1'b1;
                    if (!we_q) begin
                        bus.d_rdata = load_data;
                    end
`ifdef ARB_MISALIGN_TRAP_EN
                    if (err_q) begin
                        bus.d_err   = 1'b1;
                        bus.d_rdata = '0;
                    end
`endif
                end else begin
                    bus.if_rsp_valid = 1'b1;
                    bus.if_rdata     = bus.mem_rdata;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: doc/rv_mem_arbiter.md
Name: rv_mem_arbiter

Overview:
- Single-port arbiter/sequencer that shares one unified word-wide memory between the instruction-fetch port and the load/store port of the rv32 core.
- Accepts one request at a time, drives the memory, and returns the read data with sub-word extraction and sign extension.
- Generates byte enables and replicated write data for sb/sh/sw.
- Sits between the core's fetch/LSU stages and the memory array.

Parameters:
- ADDR_W, 6, word-address width of the memory (64 words); mem_addr = byte_addr[ADDR_W+1:2]
- MAX_DATA_STREAK, 4, consecutive data grants allowed while a fetch is pending before the fetch is forced through

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_req_valid  in  1  fetch request
- if_req_ready  out  1  fetch request accepted
- if_addr  in  32  fetch byte address; bits [1:0] ignored
- if_rsp_valid  out  1  fetch data valid, 1-cycle pulse
- if_rdata  out  32  fetched instruction word
- d_req_valid  in  1  load/store request
- d_req_ready  out  1  load/store request accepted
- d_we  in  1  1 = store, 0 = load
- d_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- d_unsigned  in  1  zero-extend loads (lbu/lhu)
- d_addr  in  32  data byte address
- d_wdata  in  32  store data, right-aligned
- d_rsp_valid  out  1  load data / store done, 1-cycle pulse
- d_rdata  out  32  extended load data; 0 for stores
- d_err  out  1  misaligned access flag, valid with d_rsp_valid
- mem_en  out  1  memory access enable
- mem_we  out  1  memory write
- mem_be  out  4  byte write enables
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  write data
- mem_rdata  in  32  read data, valid the cycle after mem_en && !mem_we

Behaviour:
- Reset is asynchronous and active-low. While reset is asserted:
  - FSM is in IDLE and the streak counter is 0.
  - All outputs are 0, including if_req_ready and d_req_ready.
- FSM states:
  - IDLE: wait for a request.
  - ACCESS: drive the memory.
  - RESP: return the response.
- IDLE:
  - Both ready outputs are combinational and only one ever asserts.
  - With no valid request, both readies are 0 and the FSM stays in IDLE.
  - On a handshake (valid && ready), latch owner, addr, size, we, unsigned and wdata, then go to ACCESS.
- Arbitration when both valids are high:
  - Data wins unless streak == MAX_DATA_STREAK, in which case fetch wins.
  - Streak increments, saturating, on a data grant while if_req_valid is high.
  - Streak clears on any fetch grant.
  - Streak is otherwise unchanged.
- ACCESS:
  - mem_en = 1, with mem_we/mem_be/mem_addr/mem_wdata driven from the latched request.
  - Next state is RESP.
  - For fetches, mem_we = 0.
- RESP:
  - Exactly one of if_rsp_valid or d_rsp_valid pulses, according to the latched owner.
  - Read data is taken combinationally from mem_rdata.
  - Next state is IDLE.
  - No backpressure on responses.
- Timing and throughput:
  - Handshake in cycle T; mem access in T+1; response in T+2; next handshake possible at T+3.
  - At most one transaction is in flight.
- Store lanes (off = addr[1:0]):
  - Byte: be = 4'b0001 << off, wdata = {4{d_wdata[7:0]}}.
  - Half: be = 4'b0011 << (2*addr[1]), wdata = {2{d_wdata[15:0]}}.
  - Word, and the illegal size 11: be = 4'b1111.
- Loads:
  - Byte: select mem_rdata[8*off +: 8].
  - Half: select mem_rdata[16*addr[1] +: 16].
  - Sign-extend unless d_unsigned.
  - Word: mem_rdata unchanged.
  - mem_be = 0 on reads.
- Address width: byte addresses beyond ADDR_W+2 bits wrap; upper bits are ignored.
- Input stability: request inputs after the handshake are don't-care because they are latched.
- Reset mid-transaction: the transaction is abandoned with no response pulse and mem_en drops immediately; the FSM returns to IDLE.

Optional Feature:
- Macro: ARB_MISALIGN_TRAP_EN. Misaligned cases:
  - half with addr[0] = 1
  - word with addr[1:0] != 0
  - d_size = 11
- Defined:
  - A misaligned data request still completes the full IDLE → ACCESS → RESP sequence.
  - In ACCESS, mem_en stays 0, so the memory is not touched.
  - In RESP, d_rsp_valid = 1, d_err = 1 and d_rdata = 0.
- Undefined:
  - d_err is tied to 0.
  - Low address bits are forced to alignment: half uses addr[1] only, word/illegal uses word alignment.
  - Sub-word selection then proceeds normally.

Test Plan:
- Reset, then fetch to 0x4 with mem[1] = 0x00100093:
  - if_req_ready = 1 in the handshake cycle; mem_en = 1 with mem_addr = 1 at T+1.
  - if_rsp_valid = 1 with if_rdata = 0x00100093 at T+2; if_req_ready = 1 again at T+3.
- sb of 0x000000AB to 0x9:
  - mem_be = 0010, mem_wdata = 0xABABABAB, mem_addr = 2.
  - d_rsp_valid at T+2 with d_rdata = 0.
- Loads with word 2 = 0x0000AB00:
  - lb 0x9 returns 0xFFFFFFAB.
  - lbu 0x9 returns 0x000000AB.
  - lh 0x8 returns 0xFFFFAB00.
  - lhu 0xA returns 0x00000000.
- Fetch and data both held valid continuously with MAX_DATA_STREAK = 4:
  - Grant order D, D, D, D, F, D, D, D, D, F.
  - No two grants are closer than 3 cycles.
- lw 0x6:
  - With ARB_MISALIGN_TRAP_EN: mem_en stays 0 and d_err = 1.
  - Without it: mem_addr = 1 and d_err = 0.
- rst_n driven low during ACCESS of a load:
  - mem_en = 0 immediately and no d_rsp_valid pulse.
  - After release, a fetch completes normally with 3-cycle spacing.
